mmio_decoder: RTL and testbench

- Parametrised memory-map decoder and access sequencer between the CPU bus and N memory-mapped slaves (ROM, RAM, terminal, future peripherals).
- Replaces hard-wired per-slave enable equations with table-driven base/mask regions.
- Adds per-region wait states, a single-cycle ready handshake, and error signalling for unmapped or illegal accesses.
- Sits in the system top between the CPU and the slave devices.

---
 rtl/mmio_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_mmio_decoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_decoder.sv
// mmio_decoder
//   Table-driven memory-map decoder and access sequencer between the CPU bus
//   and N_REGIONS memory-mapped slaves. Each region i is described by a
//   base/mask pair (hit when (addr & mask_i) == base_i) and a wait count W_i.
//   A mapped access drives sel/s_rd/s_wr for W_i+1 cycles, then pulses ready
//   for one cycle. Unmapped addresses and simultaneous rd/wr pulse ready and
//   err together one cycle after the request is sampled, with no slave access.
//   The lowest-index region wins when regions overlap.
//
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-high reset
//     addr      CPU address, held stable until ready
//     rd, wr    CPU read / write request
//     rdata     registered read data, valid while ready=1
//     ready     one-cycle completion pulse
//     err       one-cycle error pulse, coincident with ready
//     sel       one-hot slave enable
//     s_rd      slave read strobe
//     s_wr      slave write strobe
//     s_rdata   slave read data, region i at [i*DATA_WIDTH +: DATA_WIDTH]
//
//   Optional feature (macro MMIO_DECODER_ERR_CAPTURE_EN):
//     err_addr  address of the most recent erroring request
//     err_count number of err pulses since reset, saturating at 255
//
//   All outputs are registered; nothing combinational reaches an output.
module mmio_decoder #(
  parameter int unsigned N_REGIONS  = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {16'h4004, 16'h8000, 16'h4000, 16'h0000},
  parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {16'hFFFC, 16'h8000, 16'hFFFF, 16'hC000},
  parameter logic [N_REGIONS*4-1:0] REGION_WAIT =
    {4'd0, 4'd1, 4'd2, 4'd0}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic                            rd,
  input  logic                            wr,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            ready,
  output logic                            err,
  output logic [N_REGIONS-1:0]            sel,
  output logic                            s_rd,
  output logic                            s_wr,
  input  logic [N_REGIONS*DATA_WIDTH-1:0] s_rdata
`ifdef MMIO_DECODER_ERR_CAPTURE_EN
  ,
  output logic [ADDR_WIDTH-1:0]           err_addr,
  output logic [7:0]                      err_count
`endif
);

  localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t                 state, state_nx;
  logic [IDX_W-1:0]       idx_q, idx_nx;
  logic                   dir_rd_q, dir_rd_nx;
  logic [3:0]             cnt_q, cnt_nx;

  logic [DATA_WIDTH-1:0]  rdata_nx;
  logic                   ready_nx, err_nx;
  logic [N_REGIONS-1:0]   sel_nx;
  logic                   s_rd_nx, s_wr_nx;

  // Address decode: first (lowest-index) matching region wins.
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [3:0]             hit_wait;
  logic [N_REGIONS-1:0]   hit_onehot;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_wait   = '0;
    hit_onehot = '0;
    for (int unsigned i = 0; i < N_REGIONS; i++) begin
      if (!hit &&
          ((addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit           = 1'b1;
        hit_idx       = IDX_W'(i);
        hit_wait      = REGION_WAIT[i*4 +: 4];
        hit_onehot[i] = 1'b1;
      end
    end
  end

  // Read data of the latched region.
  logic [DATA_WIDTH-1:0]  slave_word;

  always_comb begin
    slave_word = '0;
    for (int unsigned i = 0; i < N_REGIONS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slave_word = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // and registered, so a state and its outputs change on the same edge.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx_q;
    dir_rd_nx = dir_rd_q;
    cnt_nx    = cnt_q;
    rdata_nx  = rdata;
    ready_nx  = 1'b0;
    err_nx    = 1'b0;
    sel_nx    = '0;
    s_rd_nx   = 1'b0;
    s_wr_nx   = 1'b0;

    unique case (state)
      IDLE: begin
        if (rd ^ wr) begin
          if (hit) begin
            state_nx  = ACCESS;
            idx_nx    = hit_idx;
            dir_rd_nx = rd;
            cnt_nx    = hit_wait;
            sel_nx    = hit_onehot;
            s_rd_nx   = rd;
            s_wr_nx   = wr;
          end else begin
            state_nx  = DONE;
            ready_nx  = 1'b1;
            err_nx    = 1'b1;
            rdata_nx  = '0;
          end
        end else if (rd && wr) begin
          state_nx = DONE;
          ready_nx = 1'b1;
          err_nx   = 1'b1;
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_nx = DONE;
          ready_nx = 1'b1;
          if (dir_rd_q) begin
            rdata_nx = slave_word;
          end
        end else begin
          cnt_nx  = cnt_q - 4'd1;
          sel_nx  = sel;
          s_rd_nx = dir_rd_q;
          s_wr_nx = !dir_rd_q;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx_q    <= '0;
      dir_rd_q <= 1'b0;
      cnt_q    <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      sel      <= '0;
      s_rd     <= 1'b0;
      s_wr     <= 1'b0;
    end else begin
      state    <= state_nx;
      idx_q    <= idx_nx;
      dir_rd_q <= dir_rd_nx;
      cnt_q    <= cnt_nx;
      rdata    <= rdata_nx;
      ready    <= ready_nx;
      err      <= err_nx;
      sel      <= sel_nx;
      s_rd     <= s_rd_nx;
      s_wr     <= s_wr_nx;
    end
  end

`ifdef MMIO_DECODER_ERR_CAPTURE_EN
  // Errors only arise from IDLE, where addr is still the offending request,
  // so capturing on the same edge that raises err needs no extra address latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr  <= '0;
      err_count <= '0;
    end else if (err_nx) begin
      err_addr <= addr;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mmio_decoder.sv
module tb_mmio_decoder;

  logic         clk;
  logic         rst;
  logic [15:0]  addr;
  logic         rd;
  logic         wr;
  logic [31:0]  rdata;
  logic         ready;
  logic         err;
  logic [3:0]   sel;
  logic         s_rd;
  logic         s_wr;
  logic [127:0] s_rdata;
`ifdef MMIO_DECODER_ERR_CAPTURE_EN
  logic [15:0]  err_addr;
  logic [7:0]   err_count;
`endif

  int vectors;
  int miscompares;

  mmio_decoder #(
    .N_REGIONS (4),
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .sel      (sel),
    .s_rd     (s_rd),
    .s_wr     (s_wr),
    .s_rdata  (s_rdata)
`ifdef MMIO_DECODER_ERR_CAPTURE_EN
    ,
    .err_addr (err_addr),
    .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request from IDLE and observes the bus until ready (bounded).
  // latency counts cycles from the sampling edge to ready; 99 means timeout.
  task automatic run_access(input logic rdv, input logic wrv, input logic [15:0] a,
                            output int latency, output int rd_cycles,
                            output int wr_cycles, output logic [3:0] sel_seen,
                            output logic got_err, output logic [31:0] got_rdata,
                            output logic [3:0] sel_at_ready);
    int cycles;
    logic done;
    cycles = 0; done = 1'b0; rd_cycles = 0; wr_cycles = 0;
    sel_seen = '0; got_err = 1'b0; got_rdata = '0; sel_at_ready = '0;
    addr = a; rd = rdv; wr = wrv;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      sel_seen |= sel;
      if (s_rd) rd_cycles++;
      if (s_wr) wr_cycles++;
      if (ready) begin
        done = 1'b1;
        got_err = err;
        got_rdata = rdata;
        sel_at_ready = sel | {2'b00, s_rd, s_wr};
      end
    end
    latency = done ? cycles : 99;
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({ready, err, sel, s_rd, s_wr} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000000", {ready, err, sel, s_rd, s_wr});
    end
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h want 00000000", rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_w0;
    int lat, rc, wc; logic [3:0] ss, sr; logic e; logic [31:0] d;
    run_access(1'b1, 1'b0, 16'h0123, lat, rc, wc, ss, e, d, sr);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL r0_latency: got %0d want 2", lat); end
    vectors++;
    if (ss !== 4'b0001) begin miscompares++; $display("FAIL r0_sel: got %b want 0001", ss); end
    vectors++;
    if (rc !== 1 || wc !== 0) begin
      miscompares++; $display("FAIL r0_strobes: got rd=%0d wr=%0d want rd=1 wr=0", rc, wc);
    end
    vectors++;
    if (d !== 32'hDEADBEEF || e !== 1'b0) begin
      miscompares++; $display("FAIL r0_data: got %h err=%b want deadbeef err=0", d, e);
    end
    vectors++;
    if (sr !== 4'b0000) begin miscompares++; $display("FAIL r0_done_idle: got %b want 0000", sr); end
  endtask

  task automatic test_reset_mid_access;
    int lat, rc, wc; logic [3:0] ss, sr; logic e; logic [31:0] d;
    int ready_seen;
    addr = 16'h8010; rd = 1'b1; wr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (sel !== 4'b0100 || s_rd !== 1'b1) begin
      miscompares++; $display("FAIL mid_strobe2: got sel=%b s_rd=%b want 0100 1", sel, s_rd);
    end
    rst = 1'b1; rd = 1'b0;
    #1;
    vectors++;
    if ({ready, err, sel, s_rd, s_wr} !== 8'h00 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got ctrl=%b rdata=%h want 0 0",
               {ready, err, sel, s_rd, s_wr}, rdata);
    end
    ready_seen = 0;
    repeat (2) begin @(posedge clk); #1; if (ready) ready_seen++; end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (ready) ready_seen++; end
    vectors++;
    if (ready_seen !== 0) begin
      miscompares++; $display("FAIL mid_no_ready: got %0d pulses want 0", ready_seen);
    end
    run_access(1'b1, 1'b0, 16'h8010, lat, rc, wc, ss, e, d, sr);
    vectors++;
    if (lat !== 3 || rc !== 2 || ss !== 4'b0100) begin
      miscompares++;
      $display("FAIL mid_retry: got lat=%0d rd=%0d sel=%b want 3 2 0100", lat, rc, ss);
    end
    vectors++;
    if (d !== 32'hCAFEF00D || e !== 1'b0) begin
      miscompares++; $display("FAIL mid_retry_data: got %h err=%b want cafef00d 0", d, e);
    end
  endtask

  task automatic test_write_w2;
    int lat, rc, wc; logic [3:0] ss, sr; logic e; logic [31:0] d;
    run_access(1'b0, 1'b1, 16'h4000, lat, rc, wc, ss, e, d, sr);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL wr_latency: got %0d want 4", lat); end
    vectors++;
    if (ss !== 4'b0010 || wc !== 3 || rc !== 0) begin
      miscompares++;
      $display("FAIL wr_strobes: got sel=%b wr=%0d rd=%0d want 0010 3 0", ss, wc, rc);
    end
    vectors++;
    if (d !== 32'hCAFEF00D || e !== 1'b0) begin
      miscompares++; $display("FAIL wr_rdata_kept: got %h err=%b want cafef00d 0", d, e);
    end
  endtask

  task automatic test_unmapped;
    int lat, rc, wc; logic [3:0] ss, sr; logic e; logic [31:0] d;
    run_access(1'b1, 1'b0, 16'h4001, lat, rc, wc, ss, e, d, sr);
    vectors++;
    if (lat !== 1 || e !== 1'b1) begin
      miscompares++; $display("FAIL unmapped_err: got lat=%0d err=%b want 1 1", lat, e);
    end
    vectors++;
    if (ss !== 4'b0000 || rc !== 0 || wc !== 0) begin
      miscompares++;
      $display("FAIL unmapped_nostrobe: got sel=%b rd=%0d wr=%0d want 0", ss, rc, wc);
    end
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_rdata: got %h want 0", d); end
`ifdef MMIO_DECODER_ERR_CAPTURE_EN
    vectors++;
    if (err_addr !== 16'h4001 || err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL unmapped_capture: got addr=%h cnt=%0d want 4001 1", err_addr, err_count);
    end
`endif
  endtask

  task automatic test_rd_wr_both;
    int lat, rc, wc; logic [3:0] ss, sr; logic e; logic [31:0] d;
    run_access(1'b1, 1'b1, 16'h8000, lat, rc, wc, ss, e, d, sr);
    vectors++;
    if (lat !== 1 || e !== 1'b1) begin
      miscompares++; $display("FAIL both_err: got lat=%0d err=%b want 1 1", lat, e);
    end
    vectors++;
    if (ss !== 4'b0000 || rc !== 0 || wc !== 0) begin
      miscompares++;
      $display("FAIL both_nostrobe: got sel=%b rd=%0d wr=%0d want 0", ss, rc, wc);
    end
`ifdef MMIO_DECODER_ERR_CAPTURE_EN
    vectors++;
    if (err_addr !== 16'h8000 || err_count !== 8'd2) begin
      miscompares++;
      $display("FAIL both_capture: got addr=%h cnt=%0d want 8000 2", err_addr, err_count);
    end
`endif
  endtask

  task automatic test_priority;
    int lat, rc, wc; logic [3:0] ss, sr; logic e; logic [31:0] d;
    run_access(1'b1, 1'b0, 16'h4005, lat, rc, wc, ss, e, d, sr);
    vectors++;
    if (ss !== 4'b1000 || lat !== 2 || rc !== 1) begin
      miscompares++;
      $display("FAIL region3_sel: got sel=%b lat=%0d rd=%0d want 1000 2 1", ss, lat, rc);
    end
    vectors++;
    if (d !== 32'h0BADC0DE || e !== 1'b0) begin
      miscompares++; $display("FAIL region3_data: got %h err=%b want 0badc0de 0", d, e);
    end
  endtask

  task automatic test_all_ones;
    int lat, rc, wc; logic [3:0] ss, sr; logic e; logic [31:0] d;
    run_access(1'b1, 1'b0, 16'hFFFF, lat, rc, wc, ss, e, d, sr);
    vectors++;
    if (ss !== 4'b0100 || lat !== 3 || rc !== 2) begin
      miscompares++;
      $display("FAIL ffff_decode: got sel=%b lat=%0d rd=%0d want 0100 3 2", ss, lat, rc);
    end
    vectors++;
    if (d !== 32'hCAFEF00D || e !== 1'b0) begin
      miscompares++; $display("FAIL ffff_data: got %h err=%b want cafef00d 0", d, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] ready_pat, sel_pat;
    ready_pat = '0; sel_pat = '0;
    addr = 16'h0123; rd = 1'b1; wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ready_pat[i] = ready;
      sel_pat[i] = |sel;
    end
    rd = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ready_pat !== 5'b10010) begin
      miscompares++; $display("FAIL b2b_ready: got %b want 10010", ready_pat);
    end
    vectors++;
    if (sel_pat !== 5'b01001) begin
      miscompares++; $display("FAIL b2b_sel: got %b want 01001", sel_pat);
    end
  endtask

`ifdef MMIO_DECODER_ERR_CAPTURE_EN
  task automatic test_err_saturate;
    for (int i = 0; i < 300; i++) begin
      addr = 16'h1234; rd = 1'b1; wr = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
      @(posedge clk); #1;
    end
    vectors++;
    if (err_count !== 8'd255 || err_addr !== 16'h1234) begin
      miscompares++;
      $display("FAIL err_saturate: got cnt=%0d addr=%h want 255 1234", err_count, err_addr);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    s_rdata = {32'h0BADC0DE, 32'hCAFEF00D, 32'h11111111, 32'hDEADBEEF};
    test_reset;
    test_read_w0;
    test_reset_mid_access;
    test_write_w2;
    test_unmapped;
    test_rd_wr_both;
    test_priority;
    test_all_ones;
    test_back_to_back;
`ifdef MMIO_DECODER_ERR_CAPTURE_EN
    test_err_saturate;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
